// File: rtl/sdp_sram_ctrl.sv
// Simple-dual-port SRAM with byte-enable writes, 1/2-cycle read latency,
// selectable read-during-write result and a zeroing clear engine.
module sdp_sram_ctrl #(
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 5,
    parameter int RD_LATENCY    = 1,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_en_in,
    input  logic [AWIDTH-1:0]     wr_addr_in,
    input  logic [DWIDTH/8-1:0]   wr_be_in,
    input  logic [DWIDTH-1:0]     wr_data_in,
    input  logic                  rd_en_in,
    input  logic [AWIDTH-1:0]     rd_addr_in,
    output logic [DWIDTH-1:0]     rd_data_out,
    output logic                  rd_valid_out,
    input  logic                  init_req_in,
    output logic                  ready_out,
    output logic                  init_busy_out
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int DEPTH  = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

    if ((DWIDTH % 8) != 0 || DWIDTH <= 0) begin : g_bad_dwidth
        $error("sdp_sram_ctrl: DWIDTH must be a positive multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sdp_sram_ctrl: RD_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    function automatic logic [DWIDTH-1:0] f_merge(
        input logic [DWIDTH-1:0] old_word,
        input logic [DWIDTH-1:0] new_word,
        input logic [NBYTES-1:0] be
    );
        logic [DWIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    logic [DWIDTH-1:0] r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [AWIDTH-1:0] r_clr_addr;
    logic              w_ready;
    logic              w_busy;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_rdw_hit;
    logic [DWIDTH-1:0] w_wr_merged;
    logic [DWIDTH-1:0] w_rd_word;
    logic [DWIDTH-1:0] r_rd_data_p0;
    logic              r_rd_vld_p0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= RST_STATE;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (init_req_in) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_busy = 1'b1;
                // The counter wraps to 0 on this same edge.
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = RST_STATE;
        endcase
    end

    assign ready_out     = w_ready;
    assign init_busy_out = w_busy;

    assign w_wr_acc    = wr_en_in & w_ready;
    assign w_rd_acc    = rd_en_in & w_ready;
    assign w_wr_merged = f_merge(r_mem[wr_addr_in], wr_data_in, wr_be_in);
    assign w_rdw_hit   = (RDW_MODE != 0) && w_wr_acc && (wr_addr_in == rd_addr_in);
    assign w_rd_word   = w_rdw_hit ? w_wr_merged : r_mem[rd_addr_in];

    always_ff @(posedge clk_in) begin
        if (w_busy && !rst_in) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[wr_addr_in] <= w_wr_merged;
        end
    end

    // Read stage p0: array output captured; data holds between reads.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rd_data_p0 <= '0;
            r_rd_vld_p0  <= 1'b0;
        end else begin
            r_rd_vld_p0 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data_p0 <= w_rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DWIDTH-1:0] r_rd_data_p1;
        logic              r_rd_vld_p1;

        // Read stage p1: optional extra register for timing.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                r_rd_data_p1 <= '0;
                r_rd_vld_p1  <= 1'b0;
            end else begin
                r_rd_vld_p1 <= r_rd_vld_p0;
                if (r_rd_vld_p0) begin
                    r_rd_data_p1 <= r_rd_data_p0;
                end
            end
        end

        assign rd_data_out  = r_rd_data_p1;
        assign rd_valid_out = r_rd_vld_p1;
    end else begin : g_lat1
        assign rd_data_out  = r_rd_data_p0;
        assign rd_valid_out = r_rd_vld_p0;
    end

endmodule

// File: tb/tb_sdp_sram_ctrl.sv
// Scoreboard bench: two instances (latency 1 / old-data and latency 2 / new-data)
// share one randomized stimulus stream checked against an array model.
module tb_sdp_sram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          init_req;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic          ready0, ready1;
    logic          busy0, busy1;

    always #5 clk = ~clk;

    sdp_sram_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)) u_dut0 (
        .clk_in(clk), .rst_in(rst),
        .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_be_in(wr_be), .wr_data_in(wr_data),
        .rd_en_in(rd_en), .rd_addr_in(rd_addr),
        .rd_data_out(rd_data0), .rd_valid_out(rd_valid0),
        .init_req_in(init_req), .ready_out(ready0), .init_busy_out(busy0)
    );

    sdp_sram_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst),
        .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_be_in(wr_be), .wr_data_in(wr_data),
        .rd_en_in(rd_en), .rd_addr_in(rd_addr),
        .rd_data_out(rd_data1), .rd_valid_out(rd_valid1),
        .init_req_in(init_req), .ready_out(ready1), .init_busy_out(busy1)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] model [DEPTH];
    int            m_left = DEPTH;
    int            cyc    = 0;
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] last0  = '0;
    logic [DW-1:0] last1  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic mon_port(input int p, input logic v, input logic [DW-1:0] d);
        exp_t e;
        bit   have;
        if (rst) begin
            chk(p == 0 ? "rst_valid0" : "rst_valid1", 32'(v), 32'd0);
            chk(p == 0 ? "rst_data0" : "rst_data1", d, 32'd0);
            if (p == 0) begin last0 = '0; q0.delete(); end
            else begin last1 = '0; q1.delete(); end
            return;
        end
        have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (v) begin
            if (!have) begin
                chk(p == 0 ? "spurious_valid0" : "spurious_valid1", 32'(v), 32'd0);
            end else begin
                if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk(p == 0 ? "rd_data0" : "rd_data1", d, e.data);
                chk(p == 0 ? "rd_latency0" : "rd_latency1", 32'(cyc), 32'(e.due));
                if (p == 0) last0 = e.data; else last1 = e.data;
            end
        end else begin
            if (have) begin
                if (p == 0) e = q0[0]; else e = q1[0];
                if (e.due <= cyc) begin
                    chk(p == 0 ? "missing_valid0" : "missing_valid1", 32'(v), 32'd1);
                    if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
            chk(p == 0 ? "rd_hold0" : "rd_hold1", d, p == 0 ? last0 : last1);
        end
    endtask

    always @(negedge clk) begin
        chk("ready0", 32'(ready0), 32'(m_left == 0));
        chk("busy0", 32'(busy0), 32'(m_left != 0));
        chk("ready1", 32'(ready1), 32'(m_left == 0));
        chk("busy1", 32'(busy1), 32'(m_left != 0));
        mon_port(0, rd_valid0, rd_data0);
        mon_port(1, rd_valid1, rd_data1);
    end

    // Drives one cycle of stimulus, records expected read results, then
    // advances the model across the clock edge.
    task automatic step(input bit we, input int wa, input logic [NB-1:0] be, input logic [DW-1:0] wd,
                        input bit re, input int ra, input bit ir);
        exp_t          e;
        logic [DW-1:0] old_rd;
        bit            rdy;
        rdy      = (m_left == 0);
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_be    = be;
        wr_data  = wd;
        rd_en    = re;
        rd_addr  = AW'(ra);
        init_req = ir;
        if (rdy && re) begin
            old_rd = model[ra];
            e.data = old_rd;
            e.due  = cyc + 1;
            q0.push_back(e);
            e.data = (we && wa == ra) ? merge(old_rd, wd, be) : old_rd;
            e.due  = cyc + 2;
            q1.push_back(e);
        end
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) for (int k = 0; k < DEPTH; k++) model[k] = '0;
        end else begin
            if (we) model[wa] = merge(model[wa], wd, be);
            if (ir) m_left = DEPTH;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 0; rd_addr = '0; init_req = 0;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Power-on sweep; user requests during it must be dropped.
        for (int i = 0; i < DEPTH; i++) step(1, 5, 4'hF, 32'hCAFE0000 + i, 1, 5, 0);
        step(0, 0, '0, '0, 1, 7, 0);
        step(0, 0, '0, '0, 1, 5, 0);

        step(1, 3, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        step(1, 3, 4'h5, 32'h11223344, 0, 0, 0);
        step(0, 0, '0, '0, 1, 3, 0);

        step(1, 9, 4'hF, 32'h12345678, 0, 0, 0);
        step(1, 9, 4'hF, 32'hA5A5A5A5, 1, 9, 0);
        step(0, 0, '0, '0, 1, 9, 0);

        for (int i = 0; i < 4; i++) step(1, i, 4'hF, 32'(10 + i), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1, i, 0);
        step(1, 0, 4'h0, 32'hFFFFFFFF, 0, 0, 0);
        step(0, 0, '0, '0, 1, 0, 0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            int wa;
            int ra;
            wa = $urandom_range(0, DEPTH - 1);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
            step($urandom_range(0, 1) == 1, wa, NB'($urandom), $urandom,
                 $urandom_range(0, 1) == 1, ra, $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 40 && m_left > 0; i++) idle(1);
        idle(3);

        // Populate, start a sweep, then reset it part way through.
        for (int i = 0; i < DEPTH; i++) step(1, i, 4'hF, $urandom | 32'h1, 0, 0, 0);
        step(0, 0, '0, '0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, i, 4'hF, 32'hBAD00000 + i, 1, i, 0);
        #1 rst = 1'b1;
        m_left = DEPTH;
        wr_en = 0; rd_en = 0; init_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) step(1, (i * 7) % DEPTH, 4'hF, 32'hBEEF0000 + i, 1, i, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, '0, '0, 1, i, 0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdp_sram_ctrl.md
Name: sdp_sram_ctrl

Overview:
Parametrised simple-dual-port SRAM for the multi-port cache data path. It supersedes the plain write-port/read-port array. It adds byte-enable writes, selectable read latency (1 or 2), a defined read-during-write policy, valid tagging on read data, and a built-in clear engine that zeroes the array after reset or on request. One write port and one read port share a single clock.

Parameters:
DWIDTH, 32, data width in bits; must be a multiple of 8
AWIDTH, 5, address width; depth = 2^AWIDTH words
RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2
RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (merged) data
INIT_ON_RESET, 1, 1 = clear engine runs automatically after reset release

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset, asynchronous, active-high
wr_en_in  input  1  write request
wr_addr_in  input  AWIDTH  write address
wr_be_in  input  DWIDTH/8  byte enables; bit i covers bits [8i+7:8i]
wr_data_in  input  DWIDTH  write data
rd_en_in  input  1  read request
rd_addr_in  input  AWIDTH  read address
rd_data_out  output  DWIDTH  read data
rd_valid_out  output  1  rd_data_out carries a new read result this cycle
init_req_in  input  1  start a clear sweep; level sampled only in IDLE
ready_out  output  1  array accepts user reads and writes
init_busy_out  output  1  clear sweep in progress

Behaviour:
- Clock and reset: clk_in is the only clock. rst_in is asynchronous and active-high.
- Reset values:
  - rd_data_out = 0, rd_valid_out = 0, and read pipeline registers = 0.
  - Clear address counter = 0.
  - FSM = CLEAR if INIT_ON_RESET = 1, else IDLE.
  - init_busy_out = (FSM == CLEAR). ready_out = (FSM == IDLE).
  - rst_in does not touch array contents directly.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR: init_req_in = 1 at a clock edge.
  - In CLEAR, each cycle writes all-zero to the address held in the counter, then increments the counter.
  - CLEAR -> IDLE: on the edge that writes address 2^AWIDTH-1. The counter returns to 0.
  - A sweep takes exactly 2^AWIDTH cycles. ready_out rises the cycle after the last clear write.
- Reset during CLEAR: the FSM returns to its reset state immediately. If INIT_ON_RESET = 1, the sweep restarts from address 0 after release.
- While ready_out = 0:
  - wr_en_in and rd_en_in are ignored and the array is not modified by the user port.
  - rd_valid_out stays 0 for those requests.
  - init_req_in is ignored during CLEAR; there is no queuing.
- Write: when wr_en_in = 1 and ready_out = 1, the array at wr_addr_in updates on the edge. Only bytes with wr_be_in[i] = 1 change. wr_be_in = 0 is a legal no-op.
- Read with RD_LATENCY = 1: a read accepted at edge N drives rd_data_out and rd_valid_out = 1 after edge N (cycle N+1).
- Read with RD_LATENCY = 2: data and valid pass through one extra register and appear after edge N+1.
- rd_data_out holds its last value when no read completes. rd_valid_out is a one-cycle pulse per accepted read.
- Back-to-back reads are accepted every cycle at full throughput.
- Read-during-write to the same address in the same cycle:
  - RDW_MODE = 0: rd_data_out returns the pre-write word.
  - RDW_MODE = 1: rd_data_out returns the merged word (enabled bytes from wr_data_in, others from the array).
- A read one cycle after a write to the same address returns the updated word in both modes.
- Different addresses in the same cycle: read and write are independent.
- Reads of never-written addresses after a completed sweep return 0. Without a sweep, contents are undefined; the bench must not check them.
- Illegal RD_LATENCY or a DWIDTH that is not a multiple of 8 is an elaboration error.

Test Plan:
- Reset then release, INIT_ON_RESET = 1, AWIDTH = 5 -> init_busy_out = 1 for exactly 32 cycles; ready_out rises on cycle 33; a read of addr 7 returns 0 with rd_valid_out = 1 one cycle later.
- Write 0xDEADBEEF to addr 3 with be = 4'b1111, then write 0x11223344 to addr 3 with be = 4'b0101, then read addr 3 -> 0xDE22BE44.
- Same-cycle write 0xA5A5A5A5 and read of addr 9, which holds 0x12345678, with be = 4'b1111 -> 0x12345678 when RDW_MODE = 0; 0xA5A5A5A5 when RDW_MODE = 1.
- RD_LATENCY = 2, reads of addr 0..3 on four consecutive cycles with data 10..13 -> rd_valid_out high for 4 cycles starting 2 cycles after the first request; data 10, 11, 12, 13 in order.
- Pulse init_req_in after populating addresses, assert rst_in at sweep cycle 10, then release -> sweep restarts at address 0 and runs the full 32 cycles; user writes issued mid-sweep are dropped; all reads afterwards return 0.
- wr_en_in and rd_en_in asserted while init_busy_out = 1 -> no rd_valid_out pulse, and after the sweep the targeted address still reads 0.
